// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: AES inverse SubBytes over a 128-bit state.
// NUM_SBOX inverse S-boxes are time-multiplexed across the 16 bytes.

module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Undo the affine map, then invert in GF(2^8) as x^254 (0 maps to 0).
    always_comb begin
        logic [7:0] aff;
        logic [7:0] p;
        logic [7:0] r;
        aff = {a_i[6:0], a_i[7]}
            ^ {a_i[4:0], a_i[7:5]}
            ^ {a_i[1:0], a_i[7:2]}
            ^ 8'h05;
        p = aff;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        y_o = r;
    end
endmodule

module inv_subbytes_seq #(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int BEATS = 16 / NUM_SBOX;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [127:0]   work_q;
    logic [127:0]   work_d;
    logic           out_valid_q;
    logic           busy_q;
    logic [7:0]     sb_in  [NUM_SBOX];
    logic [7:0]     sb_out [NUM_SBOX];

    // Bit offset of the byte handled by lane g on beat c (byte 0 = MSB).
    function automatic logic [6:0] byte_pos(input logic [CW-1:0] c,
                                            input int g);
        logic [3:0] b;
        b = 4'(int'(c) * NUM_SBOX + g);
        return {~b, 3'b000};
    endfunction

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        inv_sbox u_sbox (
            .a_i (sb_in[g]),
            .y_o (sb_out[g])
        );
    end

    // Route the current beat's bytes from the work register into the LUTs.
    always_comb begin
        for (int g = 0; g < NUM_SBOX; g++) begin
            sb_in[g] = work_q[byte_pos(cnt_q, g) +: 8];
        end
    end

    // Write the substituted bytes back in place.
    always_comb begin
        work_d = work_q;
        for (int g = 0; g < NUM_SBOX; g++) begin
            work_d[byte_pos(cnt_q, g) +: 8] = sb_out[g];
        end
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign out_state = work_q;
    assign busy      = busy_q;

    // Sequencer: accept, run BEATS beats, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule
